// File: rtl/issue_queue_if.sv
// Rename-to-issue-queue bus: instruction insert, writeback broadcast, flush and issue port.
// Handshakes: a transfer happens on a clock edge where valid && ready are both high;
// valid may not depend on ready, and the offering side holds its fields until the transfer.
interface issue_queue_if #(
  parameter int PREG_W    = 6,
  parameter int SEQ_W     = 32,
  parameter int PAYLOAD_W = 96
);
  logic                 in_valid;
  logic                 in_ready;
  logic [SEQ_W-1:0]     in_seq;
  logic                 in_uses_rs;
  logic                 in_uses_rt;
  logic [PREG_W-1:0]    in_rs_phys;
  logic [PREG_W-1:0]    in_rt_phys;
  logic                 in_rs_rdy;
  logic                 in_rt_rdy;
  logic                 in_uses_rw;
  logic [PREG_W-1:0]    in_rw_phys;
  logic [PAYLOAD_W-1:0] in_payload;

  logic                 wb_valid;
  logic [PREG_W-1:0]    wb_phys;
  logic                 flush;

  logic                 iss_valid;
  logic                 iss_ready;
  logic [SEQ_W-1:0]     iss_seq;
  logic [PREG_W-1:0]    iss_rs_phys;
  logic [PREG_W-1:0]    iss_rt_phys;
  logic [PREG_W-1:0]    iss_rw_phys;
  logic                 iss_uses_rs;
  logic                 iss_uses_rt;
  logic                 iss_uses_rw;
  logic [PAYLOAD_W-1:0] iss_payload;

  modport master (
    output in_valid, in_seq, in_uses_rs, in_uses_rt, in_rs_phys, in_rt_phys,
           in_rs_rdy, in_rt_rdy, in_uses_rw, in_rw_phys, in_payload,
           wb_valid, wb_phys, flush, iss_ready,
    input  in_ready, iss_valid, iss_seq, iss_rs_phys, iss_rt_phys, iss_rw_phys,
           iss_uses_rs, iss_uses_rt, iss_uses_rw, iss_payload
  );

  modport slave (
    input  in_valid, in_seq, in_uses_rs, in_uses_rt, in_rs_phys, in_rt_phys,
           in_rs_rdy, in_rt_rdy, in_uses_rw, in_rw_phys, in_payload,
           wb_valid, wb_phys, flush, iss_ready,
    output in_ready, iss_valid, iss_seq, iss_rs_phys, iss_rt_phys, iss_rw_phys,
           iss_uses_rs, iss_uses_rt, iss_uses_rw, iss_payload
  );
endinterface

// File: rtl/issue_queue.sv
// Out-of-order issue queue: tag-based wakeup from writeback, oldest-first single issue,
// full squash on flush.
module issue_queue #(
  parameter int DEPTH     = 16,
  parameter int PREG_W    = 6,
  parameter int SEQ_W     = 32,
  parameter int PAYLOAD_W = 96
) (
  input  logic                     clk,
  input  logic                     rst_n,
  issue_queue_if.slave             q,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  logic [DEPTH-1:0]     ent_valid;
  logic [DEPTH-1:0]     ent_rs_rdy;
  logic [DEPTH-1:0]     ent_rt_rdy;
  logic [DEPTH-1:0]     ent_uses_rs;
  logic [DEPTH-1:0]     ent_uses_rt;
  logic [DEPTH-1:0]     ent_uses_rw;
  logic [SEQ_W-1:0]     ent_seq     [DEPTH];
  logic [PREG_W-1:0]    ent_rs_phys [DEPTH];
  logic [PREG_W-1:0]    ent_rt_phys [DEPTH];
  logic [PREG_W-1:0]    ent_rw_phys [DEPTH];
  logic [PAYLOAD_W-1:0] ent_payload [DEPTH];

  logic [DEPTH-1:0]     eligible;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic [SEQ_W-1:0]     age_diff;
  logic                 do_insert;
  logic                 do_issue;
  logic                 rs_rdy_in;
  logic                 rt_rdy_in;

  assign eligible = ent_valid & ent_rs_rdy & ent_rt_rdy;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent_valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Oldest wins: a negative modular difference means entry i precedes the current pick.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    age_diff  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_diff = ent_seq[i] - ent_seq[sel_idx];
      if (eligible[i] && (!sel_found || age_diff[SEQ_W-1])) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign q.in_ready  = (occupancy < OCC_W'(DEPTH)) && !q.flush;
  assign q.iss_valid = sel_found && !q.flush;
  assign do_insert   = q.in_valid && q.in_ready && free_found;
  assign do_issue    = q.iss_valid && q.iss_ready;

  // Writeback in the insert cycle must not be lost, so it is folded into the stored ready bit.
  assign rs_rdy_in = !q.in_uses_rs || q.in_rs_rdy || (q.wb_valid && (q.wb_phys == q.in_rs_phys));
  assign rt_rdy_in = !q.in_uses_rt || q.in_rt_rdy || (q.wb_valid && (q.wb_phys == q.in_rt_phys));

  assign q.iss_seq     = sel_found ? ent_seq[sel_idx]     : '0;
  assign q.iss_rs_phys = sel_found ? ent_rs_phys[sel_idx] : '0;
  assign q.iss_rt_phys = sel_found ? ent_rt_phys[sel_idx] : '0;
  assign q.iss_rw_phys = sel_found ? ent_rw_phys[sel_idx] : '0;
  assign q.iss_uses_rs = sel_found && ent_uses_rs[sel_idx];
  assign q.iss_uses_rt = sel_found && ent_uses_rt[sel_idx];
  assign q.iss_uses_rw = sel_found && ent_uses_rw[sel_idx];
  assign q.iss_payload = sel_found ? ent_payload[sel_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid  <= '0;
      ent_rs_rdy <= '0;
      ent_rt_rdy <= '0;
      occupancy  <= '0;
    end else if (q.flush) begin
      ent_valid <= '0;
      occupancy <= '0;
    end else begin
      if (q.wb_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_rs_phys[i] == q.wb_phys) ent_rs_rdy[i] <= 1'b1;
          if (ent_rt_phys[i] == q.wb_phys) ent_rt_rdy[i] <= 1'b1;
        end
      end
      if (do_issue) ent_valid[sel_idx] <= 1'b0;
      if (do_insert) begin
        ent_valid[free_idx]  <= 1'b1;
        ent_rs_rdy[free_idx] <= rs_rdy_in;
        ent_rt_rdy[free_idx] <= rt_rdy_in;
      end
      case ({do_insert, do_issue})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_insert) begin
      ent_seq[free_idx]     <= q.in_seq;
      ent_uses_rs[free_idx] <= q.in_uses_rs;
      ent_uses_rt[free_idx] <= q.in_uses_rt;
      ent_uses_rw[free_idx] <= q.in_uses_rw;
      ent_rs_phys[free_idx] <= q.in_rs_phys;
      ent_rt_phys[free_idx] <= q.in_rt_phys;
      ent_rw_phys[free_idx] <= q.in_rw_phys;
      ent_payload[free_idx] <= q.in_payload;
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: ordering, wakeup, bypass, full, wrap, flush and reset.
module tb_issue_queue;
  logic       clk;
  logic       rst_n;
  logic [4:0] occupancy;
  int         tests_run;
  int         tests_failed;

  issue_queue_if #(.PREG_W(6), .SEQ_W(32), .PAYLOAD_W(96)) bus ();

  issue_queue #(.DEPTH(16), .PREG_W(6), .SEQ_W(32), .PAYLOAD_W(96)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .q         (bus),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_seq = '0; bus.in_uses_rs = 1'b0; bus.in_uses_rt = 1'b0;
    bus.in_rs_phys = '0; bus.in_rt_phys = '0; bus.in_rs_rdy = 1'b0; bus.in_rt_rdy = 1'b0;
    bus.in_uses_rw = 1'b0; bus.in_rw_phys = '0; bus.in_payload = '0;
    bus.wb_valid = 1'b0; bus.wb_phys = '0; bus.flush = 1'b0; bus.iss_ready = 1'b0;
  endtask

  // Offer one fully ready instruction (not clocked).
  task automatic offer_ready(input logic [31:0] seq);
    bus.in_valid = 1'b1; bus.in_seq = seq;
    bus.in_uses_rs = 1'b1; bus.in_rs_phys = 6'd1; bus.in_rs_rdy = 1'b1;
    bus.in_uses_rt = 1'b1; bus.in_rt_phys = 6'd2; bus.in_rt_rdy = 1'b1;
    bus.in_uses_rw = 1'b0; bus.in_rw_phys = '0; bus.in_payload = {64'h0, seq};
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    step(); step();
    tests_run++; if (occupancy !== 5'd0) begin tests_failed++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    tests_run++; if (bus.iss_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_iss_valid got %0b exp 0", bus.iss_valid); end
    rst_n = 1'b1;
    step();
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %0b exp 1", bus.in_ready); end
    tests_run++; if (bus.iss_seq !== 32'd0) begin tests_failed++; $display("FAIL reset_iss_seq got %0h exp 0", bus.iss_seq); end
  endtask

  task automatic test_single();
    offer_ready(32'd5);
    bus.in_payload = 96'hABCD_0123_4567_89AB_CDEF_0011;
    bus.iss_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    tests_run++; if (bus.iss_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid got %0b exp 1", bus.iss_valid); end
    tests_run++; if (bus.iss_seq !== 32'd5) begin tests_failed++; $display("FAIL single_seq got %0h exp 5", bus.iss_seq); end
    tests_run++; if (occupancy !== 5'd1) begin tests_failed++; $display("FAIL single_occ1 got %0d exp 1", occupancy); end
    tests_run++; if (bus.iss_payload !== 96'hABCD_0123_4567_89AB_CDEF_0011) begin tests_failed++; $display("FAIL single_payload got %0h", bus.iss_payload); end
    step();
    tests_run++; if (occupancy !== 5'd0) begin tests_failed++; $display("FAIL single_occ0 got %0d exp 0", occupancy); end
    tests_run++; if (bus.iss_valid !== 1'b0) begin tests_failed++; $display("FAIL single_drained got %0b exp 0", bus.iss_valid); end
    idle();
  endtask

  task automatic test_wakeup();
    bus.iss_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_seq = 32'd10;
    bus.in_uses_rs = 1'b1; bus.in_rs_phys = 6'd33; bus.in_rs_rdy = 1'b0;
    bus.in_uses_rt = 1'b0;
    step();
    tests_run++; if (bus.iss_valid !== 1'b0) begin tests_failed++; $display("FAIL wake_blocked got %0b exp 0", bus.iss_valid); end
    offer_ready(32'd11);
    step();
    bus.in_valid = 1'b0;
    tests_run++; if (bus.iss_seq !== 32'd11) begin tests_failed++; $display("FAIL wake_younger_first got %0h exp 11", bus.iss_seq); end
    tests_run++; if (occupancy !== 5'd2) begin tests_failed++; $display("FAIL wake_occ2 got %0d exp 2", occupancy); end
    bus.wb_valid = 1'b1; bus.wb_phys = 6'd33;
    step();
    bus.wb_valid = 1'b0;
    tests_run++; if (bus.iss_valid !== 1'b1 || bus.iss_seq !== 32'd10) begin tests_failed++; $display("FAIL wake_issue got v=%0b seq=%0h exp v=1 seq=a", bus.iss_valid, bus.iss_seq); end
    tests_run++; if (occupancy !== 5'd1) begin tests_failed++; $display("FAIL wake_occ1 got %0d exp 1", occupancy); end
    step();
    // Tag 0 source: a wakeup in the current cycle must not be visible before the edge.
    bus.in_valid = 1'b1; bus.in_seq = 32'd30;
    bus.in_uses_rs = 1'b1; bus.in_rs_phys = 6'd0; bus.in_rs_rdy = 1'b0; bus.in_uses_rt = 1'b0;
    step();
    bus.in_valid = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_phys = 6'd0;
    #1;
    tests_run++; if (bus.iss_valid !== 1'b0) begin tests_failed++; $display("FAIL wake_same_cycle got %0b exp 0", bus.iss_valid); end
    step();
    bus.wb_valid = 1'b0;
    tests_run++; if (bus.iss_valid !== 1'b1 || bus.iss_seq !== 32'd30) begin tests_failed++; $display("FAIL wake_tag0 got v=%0b seq=%0h exp v=1 seq=1e", bus.iss_valid, bus.iss_seq); end
    step();
    tests_run++; if (occupancy !== 5'd0) begin tests_failed++; $display("FAIL wake_drain got %0d exp 0", occupancy); end
    idle();
  endtask

  task automatic test_bypass();
    bus.in_valid = 1'b1; bus.in_seq = 32'd20;
    bus.in_uses_rs = 1'b1; bus.in_rs_phys = 6'd40; bus.in_rs_rdy = 1'b0;
    bus.in_uses_rt = 1'b1; bus.in_rt_phys = 6'd41; bus.in_rt_rdy = 1'b1;
    bus.in_uses_rw = 1'b1; bus.in_rw_phys = 6'd7;
    bus.wb_valid = 1'b1; bus.wb_phys = 6'd40;
    step();
    bus.in_valid = 1'b0; bus.wb_valid = 1'b0;
    tests_run++; if (bus.iss_valid !== 1'b1 || bus.iss_seq !== 32'd20) begin tests_failed++; $display("FAIL bypass_issue got v=%0b seq=%0h exp v=1 seq=14", bus.iss_valid, bus.iss_seq); end
    tests_run++; if (bus.iss_rs_phys !== 6'd40 || bus.iss_rt_phys !== 6'd41 || bus.iss_rw_phys !== 6'd7) begin tests_failed++; $display("FAIL bypass_tags got %0d %0d %0d exp 40 41 7", bus.iss_rs_phys, bus.iss_rt_phys, bus.iss_rw_phys); end
    tests_run++; if ({bus.iss_uses_rs, bus.iss_uses_rt, bus.iss_uses_rw} !== 3'b111) begin tests_failed++; $display("FAIL bypass_uses got %b exp 111", {bus.iss_uses_rs, bus.iss_uses_rt, bus.iss_uses_rw}); end
    bus.iss_ready = 1'b1;
    step();
    idle();
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      offer_ready(32'd100 + 32'(i));
      step();
    end
    bus.in_valid = 1'b0;
    tests_run++; if (occupancy !== 5'd16) begin tests_failed++; $display("FAIL full_occ got %0d exp 16", occupancy); end
    tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_in_ready got %0b exp 0", bus.in_ready); end
    tests_run++; if (bus.iss_seq !== 32'd100) begin tests_failed++; $display("FAIL full_oldest got %0h exp 64", bus.iss_seq); end
    bus.iss_ready = 1'b1;
    #1;
    tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_no_reuse got %0b exp 0", bus.in_ready); end
    step();
    bus.iss_ready = 1'b0;
    tests_run++; if (occupancy !== 5'd15) begin tests_failed++; $display("FAIL full_occ15 got %0d exp 15", occupancy); end
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL full_reopen got %0b exp 1", bus.in_ready); end
    tests_run++; if (bus.iss_seq !== 32'd101) begin tests_failed++; $display("FAIL full_next got %0h exp 65", bus.iss_seq); end
    bus.iss_ready = 1'b1;
    for (int i = 0; i < 15; i++) step();
    tests_run++; if (occupancy !== 5'd0) begin tests_failed++; $display("FAIL full_drain got %0d exp 0", occupancy); end
    idle();
  endtask

  task automatic test_wrap();
    logic [31:0] ins_seq [3];
    logic [31:0] exp_seq [3];
    ins_seq[0] = 32'h0000_0000; ins_seq[1] = 32'hFFFF_FFFF; ins_seq[2] = 32'hFFFF_FFFE;
    exp_seq[0] = 32'hFFFF_FFFE; exp_seq[1] = 32'hFFFF_FFFF; exp_seq[2] = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      offer_ready(ins_seq[i]);
      step();
    end
    bus.in_valid = 1'b0;
    bus.iss_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tests_run++; if (bus.iss_valid !== 1'b1 || bus.iss_seq !== exp_seq[k]) begin tests_failed++; $display("FAIL wrap_order%0d got v=%0b seq=%0h exp %0h", k, bus.iss_valid, bus.iss_seq, exp_seq[k]); end
      step();
    end
    tests_run++; if (occupancy !== 5'd0) begin tests_failed++; $display("FAIL wrap_drain got %0d exp 0", occupancy); end
    idle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 6; i++) begin
      offer_ready(32'd200 + 32'(i));
      step();
    end
    tests_run++; if (occupancy !== 5'd6) begin tests_failed++; $display("FAIL flush_pre_occ got %0d exp 6", occupancy); end
    offer_ready(32'd206);
    bus.flush = 1'b1; bus.iss_ready = 1'b1;
    #1;
    tests_run++; if (bus.iss_valid !== 1'b0 || bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_gating got iv=%0b ir=%0b exp 0 0", bus.iss_valid, bus.in_ready); end
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    tests_run++; if (occupancy !== 5'd0) begin tests_failed++; $display("FAIL flush_occ got %0d exp 0", occupancy); end
    tests_run++; if (bus.iss_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_empty got %0b exp 0", bus.iss_valid); end
    offer_ready(32'd300);
    step();
    bus.in_valid = 1'b0;
    tests_run++; if (bus.iss_seq !== 32'd300 || occupancy !== 5'd1) begin tests_failed++; $display("FAIL flush_after got seq=%0h occ=%0d exp 12c 1", bus.iss_seq, occupancy); end
    step();
    idle();
  endtask

  task automatic test_async_reset();
    offer_ready(32'd400);
    step();
    offer_ready(32'd401);
    step();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (occupancy !== 5'd0) begin tests_failed++; $display("FAIL areset_occ got %0d exp 0", occupancy); end
    tests_run++; if (bus.iss_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_valid got %0b exp 0", bus.iss_valid); end
    step();
    rst_n = 1'b1;
    step();
    tests_run++; if (bus.iss_valid !== 1'b0 || occupancy !== 5'd0) begin tests_failed++; $display("FAIL areset_after got v=%0b occ=%0d exp 0 0", bus.iss_valid, occupancy); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    test_reset();
    test_single();
    test_wakeup();
    test_bypass();
    test_full();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
